// File: rtl/branch_resolve_bht_pkg.sv
// Shared definitions for the branch resolution / BHT block.
//   - Branch condition encodings (instruction func3 field).
//   - 2-bit saturating counter state constants.
//   - ctr_next(): saturating counter update helper.
package branch_resolve_bht_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;  // strong not-taken
    localparam logic [1:0] WNT = 2'b01;  // weak not-taken (reset value)
    localparam logic [1:0] WT  = 2'b10;  // weak taken
    localparam logic [1:0] ST  = 2'b11;  // strong taken

    // Saturating 2-bit counter: taken moves toward ST, not-taken toward SNT.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'b01;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_bht_br_cond_eval.sv
// Purely combinational branch condition evaluator.
// Ports:
//   i_func3   branch condition code
//   i_a, i_b  rs1 / rs2 operands
//   o_taken   condition outcome (0 for unsupported codes)
//   o_illegal func3 is not a supported branch condition
module br_cond_eval
    import branch_resolve_bht_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_taken,
    output logic            o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_func3)
            BEQ:     o_taken = (i_a == i_b);
            BNE:     o_taken = (i_a != i_b);
            BLT:     o_taken = ($signed(i_a) <  $signed(i_b));
            BGE:     o_taken = ($signed(i_a) >= $signed(i_b));
            BLTU:    o_taken = (i_a <  i_b);
            BGEU:    o_taken = (i_a >= i_b);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a 2-bit saturating-counter branch history table.
// Fetch side reads the BHT combinationally; execute side resolves a branch,
// updates the BHT and reports mispredicts / illegal conditions one cycle later.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   lookup_pc -> pred_taken          fetch prediction (counter MSB, no bypass)
//   res_valid, res_func3, res_a/b,
//   res_pc, res_pred_taken,
//   res_target, res_pc_plus4, flush  execute-stage resolution inputs
//   mispredict, redirect_pc          registered mispredict pulse + correct PC
//   illegal_br                       registered pulse for unsupported func3
//   br_count, mispred_count          saturating statistics counters
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   lookup_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [2:0]        res_func3,
    input  logic [XLEN-1:0]   res_a,
    input  logic [XLEN-1:0]   res_b,
    input  logic [XLEN-1:0]   res_pc,
    input  logic              res_pred_taken,
    input  logic [XLEN-1:0]   res_target,
    input  logic [XLEN-1:0]   res_pc_plus4,
    input  logic              flush,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              illegal_br,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]        r_bht [BHT_ENTRIES];
    logic              r_run;
    logic              r_mispredict;
    logic              r_illegal;
    logic [XLEN-1:0]   r_redirect_pc;
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mispred_count;

    logic [IDX_W-1:0]  w_lookup_idx;
    logic [IDX_W-1:0]  w_upd_idx;
    logic              w_taken;
    logic              w_illegal;
    logic              w_accept;
    logic              w_legal_accept;
    logic              w_unused;

    assign w_lookup_idx = lookup_pc[IDX_W+1:2];
    assign w_upd_idx    = res_pc[IDX_W+1:2];

    // Upper PC bits and byte offset do not participate in indexing.
    assign w_unused = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                        res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .i_func3   (res_func3),
        .i_a       (res_a),
        .i_b       (res_b),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    // r_run is low for the first edge after reset release, so a resolution
    // presented while reset is being released is dropped.
    assign w_accept       = res_valid & ~flush & r_run;
    assign w_legal_accept = w_accept & ~w_illegal;

    // Prediction reads the stored counter; an update in the same cycle only
    // becomes visible after the edge.
    assign pred_taken = r_bht[w_lookup_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= WNT;
            end
        end else if (w_legal_accept) begin
            r_bht[w_upd_idx] <= ctr_next(r_bht[w_upd_idx], w_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run           <= 1'b0;
            r_mispredict    <= 1'b0;
            r_illegal       <= 1'b0;
            r_redirect_pc   <= '0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
        end else begin
            r_run        <= 1'b1;
            r_mispredict <= 1'b0;
            r_illegal    <= w_accept & w_illegal;
            if (w_legal_accept) begin
                if (r_br_count != '1) begin
                    r_br_count <= r_br_count + STAT_W'(1);
                end
                if (w_taken != res_pred_taken) begin
                    r_mispredict  <= 1'b1;
                    r_redirect_pc <= w_taken ? res_target : res_pc_plus4;
                    if (r_mispred_count != '1) begin
                        r_mispred_count <= r_mispred_count + STAT_W'(1);
                    end
                end
            end
        end
    end

    assign mispredict    = r_mispredict;
    assign redirect_pc   = r_redirect_pc;
    assign illegal_br    = r_illegal;
    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: doc/branch_resolve_bht.md
BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001 Parameter XLEN, default 32, operand and PC width.
REQ-002 Parameter BHT_ENTRIES, default 64, branch history table depth; power of two, 4..1024.
REQ-003 Parameter STAT_W, default 32, statistics counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 lookup_pc  in  XLEN  fetch-stage PC to predict.
REQ-007 pred_taken  out  1  combinational prediction for lookup_pc: counter MSB.
REQ-008 res_valid  in  1  execute-stage branch present this cycle.
REQ-009 res_func3  in  3  branch condition code.
REQ-010 res_a, res_b  in  XLEN each  rs1/rs2 operands.
REQ-011 res_pc  in  XLEN  PC of resolving branch.
REQ-012 res_pred_taken  in  1  prediction made at fetch for this branch.
REQ-013 res_target, res_pc_plus4  in  XLEN each  taken and fall-through addresses.
REQ-014 flush  in  1  squash: resolution in this cycle is ignored.
REQ-015 mispredict  out  1  registered one-cycle pulse.
REQ-016 redirect_pc  out  XLEN  registered correct next PC, valid with mispredict.
REQ-017 illegal_br  out  1  registered one-cycle pulse, unsupported func3.
REQ-018 br_count, mispred_count  out  STAT_W each  statistics.

Function
REQ-019 BHT index = pc[IDX_W+1:2], IDX_W = log2(BHT_ENTRIES); bits [1:0] ignored.
REQ-020 Each entry is a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-021 Conditions: 000 A==B; 001 A!=B; 100 signed A<B; 101 signed A>=B; 110 unsigned A<B; 111 unsigned A>=B.
REQ-022 func3 010/011: outcome not-taken, illegal_br pulses, no BHT update, no mispredict, counters unchanged.
REQ-023 Accepted resolution = res_valid & !flush; anything else causes no state change.
REQ-024 Accepted legal branch: outcome != res_pred_taken -> mispredict=1 next cycle, redirect_pc = outcome ? res_target : res_pc_plus4.
REQ-025 Correct prediction: mispredict=0 next cycle; redirect_pc holds its previous value.
REQ-026 Latency: mispredict/redirect_pc/illegal_br one cycle after the accepted resolution; back-to-back resolutions each produce their own pulse.
REQ-027 BHT update at the accepted-resolution edge: taken increments, not-taken decrements, saturating at 11/00.
REQ-028 Lookup and update of the same index in one cycle: pred_taken shows the pre-update value; no bypass.
REQ-029 br_count increments per accepted legal branch; mispred_count per mispredict; both saturate at all-ones, never wrap.
REQ-030 Without res_valid, mispredict and illegal_br are 0 every cycle.

Reset
REQ-031 rst_n low asynchronously forces all BHT entries to 01, mispredict=0, illegal_br=0, redirect_pc=0, br_count=0, mispred_count=0.
REQ-032 Reset asserted while a pulse is high clears it immediately; a resolution in the cycle rst_n deasserts is ignored.

Structure
REQ-033 Shared package holds func3 encodings (BEQ, BNE, BLT, BGE, BLTU, BGEU) and counter state constants SNT/WNT/WT/ST.
REQ-034 Condition evaluation is sub-module br_cond_eval (func3, A, B -> taken, illegal), purely combinational.
REQ-035 BHT is a register array with asynchronous reset; no SRAM macro.

Verification
REQ-036 After reset, lookup_pc=0x100 -> pred_taken=0; BEQ, A=B=5, res_pred_taken=0 -> next cycle mispredict=1, redirect_pc=res_target, entry becomes 10.
REQ-037 BLT A=0xFFFFFFFF, B=1, pred 1 -> no mispredict; BLTU same operands, pred 1 -> mispredict=1, redirect_pc=res_pc_plus4.
REQ-038 Four taken resolutions at pc 0x40 -> entry 11; a fifth stays 11; one not-taken -> 10, pred_taken still 1.
REQ-039 func3=010 with res_valid -> illegal_br pulse, br_count unchanged, entry unchanged; res_valid with flush=1 -> no outputs, no update.
REQ-040 pc 0x40 and 0x140 (BHT_ENTRIES=64) alias to one entry; lookup of 0x40 during an update to 0x140 returns the old value.
REQ-041 STAT_W=4: 20 mispredicting branches -> br_count=mispred_count=15; rst_n pulsed mid-stream clears both and all entries to 01.
